// File: rtl/psum_line_accumulator_if.sv
// Bundles the stream, FIFO and status signals of psum_line_accumulator.
//   slave  : accumulator side (takes start/num_passes/in_*/fifo_do, drives everything else)
//   master : environment side (stream source, line FIFO, output consumer)
// Signals:
//   start, num_passes        job control
//   in_valid, in_data, in_ready   partial-sum input stream
//   fifo_wren, fifo_di, fifo_rden, fifo_do, fifo_clr   BRAM line FIFO control/data
//   out_valid, out_data      completed sums
//   busy, done               job status
interface psum_line_accumulator_if #(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH = 25,
   parameter int unsigned PASS_W     = 8
);
   logic                  start;
   logic [PASS_W-1:0]     num_passes;
   logic                  in_valid;
   logic [IN_WIDTH-1:0]   in_data;
   logic                  in_ready;
   logic                  fifo_wren;
   logic [DATA_WIDTH-1:0] fifo_di;
   logic                  fifo_rden;
   logic [DATA_WIDTH-1:0] fifo_do;
   logic                  fifo_clr;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  busy;
   logic                  done;

   modport master (
      output start, num_passes, in_valid, in_data, fifo_do,
      input  in_ready, fifo_wren, fifo_di, fifo_rden, fifo_clr, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, num_passes, in_valid, in_data, fifo_do,
      output in_ready, fifo_wren, fifo_di, fifo_rden, fifo_clr, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/psum_line_accumulator.sv
// Multi-pass partial-sum accumulator in front of a BRAM line FIFO.
// Pass 0 stores the incoming line, middle passes read back, add and write back, and the
// last pass emits the completed sums. With a single pass the input goes straight out.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  psum_line_accumulator_if.slave (stream in, FIFO control/data, sums out, busy/done)
// Build option: define PSUM_SATURATE_EN to clamp sums on signed overflow; otherwise
// sums wrap in two's complement and no clamp logic exists.
module psum_line_accumulator #(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH = 25,
   parameter int unsigned DEPTH      = 717,
   parameter int unsigned PASS_W     = 8
) (
   input logic                    clk,
   input logic                    rst,
   psum_line_accumulator_if.slave bus
);

   localparam int unsigned       ELEM_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

   state_e                state_q, state_d;
   logic [PASS_W-1:0]     passes_q, passes_d;
   logic [PASS_W-1:0]     pass_q, pass_d;
   logic [ELEM_W-1:0]     elem_q, elem_d;
   logic                  done_q, done_d;

   logic                  accept, last_pass, read_pass;
   logic [DATA_WIDTH-1:0] x, addend, sum;

   // Stage 1: the cycle after acceptance, where fifo_do is valid.
   logic                  s1_valid_q, s1_rd_q, s1_wr_q;
   logic [DATA_WIDTH-1:0] s1_x_q;

   // Stage 2: registered output.
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   assign x         = DATA_WIDTH'($signed(bus.in_data));
   assign accept    = (state_q == StAccum) && bus.in_valid;
   assign last_pass = (pass_q == passes_q - PASS_W'(1));
   // Pass 0 of a multi-pass job and single-pass jobs never touch the stored line.
   assign read_pass = (passes_q != PASS_W'(1)) && (pass_q != '0);

   assign bus.in_ready  = (state_q == StAccum);
   assign bus.fifo_rden = accept && read_pass;
   assign bus.fifo_clr  = !rst && (state_q == StIdle) && bus.start;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.fifo_wren = s1_valid_q && s1_wr_q;
   assign bus.fifo_di   = bus.fifo_wren ? sum : '0;
   assign addend        = s1_rd_q ? bus.fifo_do : '0;

`ifdef PSUM_SATURATE_EN
   logic [DATA_WIDTH:0] sum_ext;

   always_comb begin
      sum_ext = {addend[DATA_WIDTH-1], addend} + {s1_x_q[DATA_WIDTH-1], s1_x_q};
      sum     = sum_ext[DATA_WIDTH-1:0];
      // Top two bits disagree only on overflow; the true sign picks the rail.
      if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
         sum = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum = addend + s1_x_q;
`endif

   always_comb begin
      state_d  = state_q;
      passes_d = passes_q;
      pass_d   = pass_q;
      elem_d   = elem_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               passes_d = (bus.num_passes == '0) ? PASS_W'(1) : bus.num_passes;
               pass_d   = '0;
               elem_d   = '0;
               state_d  = StAccum;
            end
         end
         StAccum: begin
            if (accept) begin
               if (elem_q == ELEM_LAST) begin
                  elem_d = '0;
                  if (last_pass) begin
                     state_d = StDrain;
                  end else begin
                     pass_d = pass_q + PASS_W'(1);
                  end
               end else begin
                  elem_d = elem_q + ELEM_W'(1);
               end
            end
         end
         StDrain: begin
            // Last element sits in stage 1 on entry; once it has moved on, the
            // output register holds it and done follows one cycle later.
            if (!s1_valid_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         passes_q    <= PASS_W'(1);
         pass_q      <= '0;
         elem_q      <= '0;
         done_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_rd_q     <= 1'b0;
         s1_wr_q     <= 1'b0;
         s1_x_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         passes_q    <= passes_d;
         pass_q      <= pass_d;
         elem_q      <= elem_d;
         done_q      <= done_d;
         s1_valid_q  <= accept;
         s1_rd_q     <= read_pass;
         s1_wr_q     <= !last_pass;
         if (accept) begin
            s1_x_q <= x;
         end
         out_valid_q <= s1_valid_q && !s1_wr_q;
         if (s1_valid_q && !s1_wr_q) begin
            out_data_q <= sum;
         end
      end
   end

endmodule
